// File: rtl/kmap_vector_sweeper.sv
// kmap_vector_sweeper
//
// Purpose:
//   Exhaustively drives all sixteen input combinations {a,b,c,d} into an
//   external 4-input combinational function. The block waits a programmable
//   number of settle cycles per vector, samples the response f, and builds
//   the observed truth table. It then compares that table against an
//   expected table, skipping any don't-care minterms.
//
// Parameters:
//   EXPECTED  expected truth table, bit i = f for minterm i = {a,b,c,d}
//   DC_MASK   don't-care mask, bit i = 1 excludes minterm i from comparison
//   SETTLE    settle cycles per vector before sampling (1..15)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     one-cycle sweep request (only honoured while idle)
//   f         response of the function under test
//   a,b,c,d   registered stimulus bits (a is the MSB of the minterm index)
//   busy      high while vectors are being settled/sampled
//   done      one-cycle pulse when a sweep completes
//   pass      last sweep result, err_cnt == 0
//   tt        captured truth table of f
//   err_cnt   number of mismatching non-masked minterms (0..16)
//   fail_idx  first mismatching minterm, 0 when there is none
//
// Configuration macro:
//   KMAP_SWEEP_ABORT_ON_FAIL_EN  when defined, the first mismatch ends the
//                                sweep immediately instead of finishing all
//                                sixteen minterms.

module kmap_vector_sweeper #(
    parameter logic [15:0] EXPECTED = 16'hA488,
    parameter logic [15:0] DC_MASK  = 16'h0000,
    parameter int unsigned SETTLE   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] tt,
    output logic [4:0]  err_cnt,
    output logic [3:0]  fail_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Settle counter runs 0..SETTLE-1, so this is the count that ends settling.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] tt_q, tt_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  fail_q, fail_d;
    logic        pass_q, pass_d;
    logic        mismatch;
    logic        abort;

    // State and datapath registers. Reset puts everything back to a clean
    // idle condition at once, which also abandons any sweep in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            tt_q    <= 16'd0;
            err_q   <= 5'd0;
            fail_q  <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state and datapath logic. Each vector spends SETTLE cycles in
    // SETTLE and one cycle in SAMPLE. The sample edge writes the captured bit
    // and scores it against the expected table. The pass flag is loaded on
    // the edge that enters DONE, from the final error count, so it is
    // already valid while done is high. Results are only cleared when a new
    // sweep is accepted, so they persist through idle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        tt_d     = tt_q;
        err_d    = err_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        mismatch = 1'b0;
        abort    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    idx_d   = 4'd0;
                    cnt_d   = 4'd0;
                    tt_d    = 16'd0;
                    err_d   = 5'd0;
                    fail_d  = 4'd0;
                    pass_d  = 1'b0;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_SAMPLE: begin
                tt_d[idx_q] = f;
                mismatch    = !DC_MASK[idx_q] && (f != EXPECTED[idx_q]);
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                    // An error count of zero means this is the first mismatch.
                    if (err_q == 5'd0) begin
                        fail_d = idx_q;
                    end
                end
`ifdef KMAP_SWEEP_ABORT_ON_FAIL_EN
                abort = mismatch;
`else
                abort = 1'b0;
`endif
                if ((idx_q == 4'd15) || abort) begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == 5'd0);
                end else begin
                    state_d = ST_SETTLE;
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = 4'd0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The stimulus bits come straight from the index register. They are
    // stable for the whole settle window of each vector.
    assign {a, b, c, d} = idx_q;
    assign busy         = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done         = (state_q == ST_DONE);
    assign pass         = pass_q;
    assign tt           = tt_q;
    assign err_cnt      = err_q;
    assign fail_idx     = fail_q;

endmodule

// File: tb/tb_kmap_vector_sweeper.sv
// tb_kmap_vector_sweeper
//
// Purpose:
//   Self-checking bench for kmap_vector_sweeper. Three instances are used:
//     dut 0  defaults (SETTLE=1, no mask)
//     dut 1  SETTLE=3, partial don't-care mask
//     dut 2  SETTLE=2, everything masked
//   Each instance's f input is looked up from a bench-owned 16-bit function
//   table indexed by its {a,b,c,d} outputs. Results are predicted from the
//   table, the expected table and the mask.
//   Honours KMAP_SWEEP_ABORT_ON_FAIL_EN the same way the design does.

module tb_kmap_vector_sweeper;

    localparam logic [15:0] MASK1 = 16'h0FF0;
    localparam logic [15:0] MASK2 = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rstN    [3];
    logic        startV  [3];
    logic [15:0] fnV     [3];
    logic        fV      [3];
    logic        aV      [3];
    logic        bV      [3];
    logic        cV      [3];
    logic        dV      [3];
    logic        busyV   [3];
    logic        doneV   [3];
    logic        passV   [3];
    logic [15:0] ttV     [3];
    logic [4:0]  errV    [3];
    logic [3:0]  failV   [3];

    logic [15:0] expTab = 16'hA488;
    logic [15:0] maskTab [3];
    int          settleTab [3];

    int compareCount  = 0;
    int mismatchCount = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Each function under test is a pure table lookup on the stimulus bits.
    assign fV[0] = fnV[0][{aV[0], bV[0], cV[0], dV[0]}];
    assign fV[1] = fnV[1][{aV[1], bV[1], cV[1], dV[1]}];
    assign fV[2] = fnV[2][{aV[2], bV[2], cV[2], dV[2]}];

    kmap_vector_sweeper dut0 (
        .clk(clk), .rst_n(rstN[0]), .start(startV[0]), .f(fV[0]),
        .a(aV[0]), .b(bV[0]), .c(cV[0]), .d(dV[0]),
        .busy(busyV[0]), .done(doneV[0]), .pass(passV[0]),
        .tt(ttV[0]), .err_cnt(errV[0]), .fail_idx(failV[0])
    );

    kmap_vector_sweeper #(.DC_MASK(MASK1), .SETTLE(3)) dut1 (
        .clk(clk), .rst_n(rstN[1]), .start(startV[1]), .f(fV[1]),
        .a(aV[1]), .b(bV[1]), .c(cV[1]), .d(dV[1]),
        .busy(busyV[1]), .done(doneV[1]), .pass(passV[1]),
        .tt(ttV[1]), .err_cnt(errV[1]), .fail_idx(failV[1])
    );

    kmap_vector_sweeper #(.DC_MASK(MASK2), .SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rstN[2]), .start(startV[2]), .f(fV[2]),
        .a(aV[2]), .b(bV[2]), .c(cV[2]), .d(dV[2]),
        .busy(busyV[2]), .done(doneV[2]), .pass(passV[2]),
        .tt(ttV[2]), .err_cnt(errV[2]), .fail_idx(failV[2])
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: walk the minterms in order and score each against the
    // expected table. Latency is vectors visited times cycles per vector.
    function automatic void refModel(input logic [15:0] fn, input logic [15:0] mask,
                                     input int s, output logic [15:0] ett,
                                     output int eerr, output int efail, output int elat);
        ett   = 16'd0;
        eerr  = 0;
        efail = 0;
        elat  = 16 * (s + 1);
        for (int i = 0; i < 16; i++) begin
            ett[i] = fn[i];
            if (!mask[i] && (fn[i] != expTab[i])) begin
                if (eerr == 0) efail = i;
                eerr++;
`ifdef KMAP_SWEEP_ABORT_ON_FAIL_EN
                elat = (i + 1) * (s + 1);
                break;
`endif
            end
        end
    endfunction

    // All outputs of instance k must read zero while reset is applied.
    task automatic checkReset(input int k);
        checkOutput("rst_busy", 32'(busyV[k]), 0);
        checkOutput("rst_done", 32'(doneV[k]), 0);
        checkOutput("rst_pass", 32'(passV[k]), 0);
        checkOutput("rst_tt", 32'(ttV[k]), 0);
        checkOutput("rst_err_cnt", 32'(errV[k]), 0);
        checkOutput("rst_fail_idx", 32'(failV[k]), 0);
        checkOutput("rst_abcd", 32'({aV[k], bV[k], cV[k], dV[k]}), 0);
    endtask

    // Run one sweep on instance k with function table fn. When holdStart is
    // set, start stays high until done appears, which must not restart the
    // sweep.
    task automatic applyStimulus(input int k, input logic [15:0] fn, input bit holdStart);
        logic [15:0] ett;
        int          eerr, efail, elat, cyc;
        refModel(fn, maskTab[k], settleTab[k], ett, eerr, efail, elat);
        fnV[k] = fn;
        @(negedge clk);
        startV[k] = 1'b1;
        @(negedge clk);
        if (!holdStart) startV[k] = 1'b0;
        checkOutput("start_busy", 32'(busyV[k]), 1);
        checkOutput("start_tt_clear", 32'(ttV[k]), 0);
        checkOutput("start_err_clear", 32'(errV[k]), 0);
        checkOutput("start_pass_clear", 32'(passV[k]), 0);
        cyc = 0;
        while (!doneV[k] && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("latency", 32'(cyc), 32'(elat));
        checkOutput("done_high", 32'(doneV[k]), 1);
        checkOutput("done_busy", 32'(busyV[k]), 0);
        checkOutput("tt", 32'(ttV[k]), 32'(ett));
        checkOutput("err_cnt", 32'(errV[k]), 32'(eerr));
        checkOutput("fail_idx", 32'(failV[k]), 32'(efail));
        checkOutput("pass", 32'(passV[k]), 32'(eerr == 0));
        startV[k] = 1'b0;
        @(negedge clk);
        checkOutput("done_width", 32'(doneV[k]), 0);
        checkOutput("idle_busy", 32'(busyV[k]), 0);
        checkOutput("idle_tt_hold", 32'(ttV[k]), 32'(ett));
        checkOutput("idle_pass_hold", 32'(passV[k]), 32'(eerr == 0));
        checkOutput("idle_err_hold", 32'(errV[k]), 32'(eerr));
    endtask

    // Abandon a sweep on instance k with reset. Outputs must clear at once
    // and no done pulse may follow.
    task automatic resetMidSweep(input int k, input int cyclesIn);
        int doneSeen;
        fnV[k] = expTab;
        @(negedge clk);
        startV[k] = 1'b1;
        @(negedge clk);
        startV[k] = 1'b0;
        repeat (cyclesIn - 1) @(negedge clk);
        checkOutput("pre_reset_busy", 32'(busyV[k]), 1);
        #2;
        rstN[k] = 1'b0;
        #1;
        checkReset(k);
        doneSeen = 0;
        repeat (3) begin
            @(negedge clk);
            if (doneV[k]) doneSeen++;
        end
        rstN[k] = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (doneV[k]) doneSeen++;
        end
        checkOutput("no_done_after_reset", 32'(doneSeen), 0);
        checkOutput("idle_after_reset", 32'(busyV[k]), 0);
    endtask

    initial begin
        maskTab   = '{16'h0000, MASK1, MASK2};
        settleTab = '{1, 3, 2};
        for (int k = 0; k < 3; k++) begin
            rstN[k]   = 1'b0;
            startV[k] = 1'b0;
            fnV[k]    = 16'h0000;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) checkReset(k);
        for (int k = 0; k < 3; k++) rstN[k] = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] directed sweeps");
        applyStimulus(0, expTab, 1'b0);
        applyStimulus(0, 16'h0000, 1'b0);
        applyStimulus(2, ~expTab, 1'b0);
        applyStimulus(1, expTab, 1'b0);
        applyStimulus(1, 16'hFFFF, 1'b0);

        $display("[TB] reset mid-sweep and restart");
        resetMidSweep(1, 20);
        applyStimulus(1, expTab, 1'b0);

        $display("[TB] start held high across a sweep");
        applyStimulus(0, expTab, 1'b1);
        applyStimulus(0, 16'h0000, 1'b1);

        $display("[TB] randomized sweeps");
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 3; k++) begin
                applyStimulus(k, 16'($urandom), 1'b0);
                applyStimulus(k, expTab ^ (16'd1 << $urandom_range(15, 0)), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
